// File: rtl/serdes_tx_scheduler_if.sv
// ----------------------------------------------------------------------------
// serdes_tx_scheduler_if
//   Bundles the two byte-stream requester handshakes and the encoder-side
//   outputs of the transmit slot scheduler.
//
//   Handshake: a requester raises sX_valid with sX_data/sX_last and holds
//   all three stable until it sees sX_ready=1 in the same cycle; a byte is
//   transferred on the rising edge where sX_valid && sX_ready. sX_ready is
//   combinational and only ever high on a slot-end cycle.
//
//   Signals:
//     s0_valid/s0_data/s0_last/s0_ready  requester 0 byte stream
//     s1_valid/s1_data/s1_last/s1_ready  requester 1 byte stream
//     enc_data, enc_en                   byte and load strobe to the encoder
//     link_up                            alignment phase finished
//     grant                              one-hot owner of the open burst
//     underrun                           granted requester missed a slot
//     state_dbg                          scheduler FSM state for observation
//
//   Modports: master = requester/observer side, slave = scheduler side.
// ----------------------------------------------------------------------------
interface serdes_tx_scheduler_if;
    logic       s0_valid;
    logic [7:0] s0_data;
    logic       s0_last;
    logic       s0_ready;
    logic       s1_valid;
    logic [7:0] s1_data;
    logic       s1_last;
    logic       s1_ready;
    logic [7:0] enc_data;
    logic       enc_en;
    logic       link_up;
    logic [1:0] grant;
    logic       underrun;
    logic [1:0] state_dbg;

    modport master (
        output s0_valid, s0_data, s0_last,
        output s1_valid, s1_data, s1_last,
        input  s0_ready, s1_ready,
        input  enc_data, enc_en, link_up, grant, underrun, state_dbg
    );

    modport slave (
        input  s0_valid, s0_data, s0_last,
        input  s1_valid, s1_data, s1_last,
        output s0_ready, s1_ready,
        output enc_data, enc_en, link_up, grant, underrun, state_dbg
    );
endinterface

// File: rtl/serdes_tx_scheduler.sv
// ----------------------------------------------------------------------------
// serdes_tx_scheduler
//   Transmit-side slot scheduler ahead of an 8b/10b encoder. Every symbol
//   slot of SYM_CYCLES clocks it picks one byte and pulses enc_en once.
//   After reset it sends ALIGN_SYMS idle symbols, then raises link_up and
//   shares the encoder between two requesters with round-robin arbitration
//   that locks onto a requester for the duration of a burst (until last).
//   Slots with nothing to send carry IDLE_BYTE.
//
//   Ports:
//     clk    single clock
//     rst_n  synchronous active-low reset
//     bus    serdes_tx_scheduler_if.slave (requester handshakes, encoder
//            outputs, link/grant/underrun status, FSM state)
// ----------------------------------------------------------------------------
module serdes_tx_scheduler #(
    parameter int          SYM_CYCLES = 10,
    parameter int          ALIGN_SYMS = 4,
    parameter logic [7:0]  IDLE_BYTE  = 8'hBC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serdes_tx_scheduler_if.slave   bus
);
    localparam int CW = $clog2(SYM_CYCLES);
    localparam int AW = $clog2(ALIGN_SYMS) + 1;

    typedef enum logic [1:0] {
        ST_ALIGN = 2'd0,
        ST_IDLE  = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [AW-1:0] align_cnt, align_nx;
    logic          rr, rr_nx;          // 0 favours requester 0
    logic [1:0]    grant_q, grant_nx;
    logic          link_q, link_nx;
    logic [7:0]    enc_data_q;
    logic          enc_en_q;
    logic          underrun_q, under_nx;
    logic [7:0]    sel_byte;
    logic          rdy0, rdy1;
    logic          slot_end;
    logic          pick0, pick1;
    logic          own_valid, own_last;
    logic [7:0]    own_data;

    assign slot_end = (cnt == CW'(SYM_CYCLES - 1));

    // Arbitration when no burst is open: a lone valid wins outright, a tie
    // goes to whichever requester the round-robin pointer favours.
    assign pick0 = bus.s0_valid && (!bus.s1_valid || !rr);
    assign pick1 = bus.s1_valid && !pick0;

    // Signals of the requester that currently owns the open burst.
    assign own_valid = grant_q[0] ? bus.s0_valid : bus.s1_valid;
    assign own_data  = grant_q[0] ? bus.s0_data  : bus.s1_data;
    assign own_last  = grant_q[0] ? bus.s0_last  : bus.s1_last;

    always_comb begin
        state_nx = state;
        align_nx = align_cnt;
        rr_nx    = rr;
        grant_nx = grant_q;
        link_nx  = link_q;
        under_nx = 1'b0;
        sel_byte = IDLE_BYTE;
        rdy0     = 1'b0;
        rdy1     = 1'b0;
        if (slot_end) begin
            unique case (state)
                ST_ALIGN: begin
                    // link_up rises together with the enc_en of the last
                    // alignment idle.
                    if (align_cnt == AW'(ALIGN_SYMS - 1)) begin
                        state_nx = ST_IDLE;
                        link_nx  = 1'b1;
                    end else begin
                        align_nx = align_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (pick0 || pick1) begin
                        rdy0     = pick0;
                        rdy1     = pick1;
                        sel_byte = pick0 ? bus.s0_data : bus.s1_data;
                        if (pick0 ? bus.s0_last : bus.s1_last) begin
                            // Single-byte burst: no grant is held.
                            rr_nx = ~rr;
                        end else begin
                            state_nx = ST_DATA;
                            grant_nx = pick0 ? 2'b01 : 2'b10;
                        end
                    end
                end
                ST_DATA: begin
                    if (own_valid) begin
                        rdy0     = grant_q[0];
                        rdy1     = grant_q[1];
                        sel_byte = own_data;
                        if (own_last) begin
                            state_nx = ST_IDLE;
                            grant_nx = 2'b00;
                            // Favour the requester that did not just finish.
                            rr_nx    = grant_q[0];
                        end
                    end else begin
                        under_nx = 1'b1;
                    end
                end
                default: state_nx = ST_ALIGN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            state      <= ST_ALIGN;
            align_cnt  <= '0;
            rr         <= 1'b0;
            grant_q    <= 2'b00;
            link_q     <= 1'b0;
            enc_data_q <= IDLE_BYTE;
            enc_en_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt        <= slot_end ? '0 : cnt + 1'b1;
            state      <= state_nx;
            align_cnt  <= align_nx;
            rr         <= rr_nx;
            grant_q    <= grant_nx;
            link_q     <= link_nx;
            enc_en_q   <= slot_end;
            underrun_q <= under_nx;
            if (slot_end) begin
                enc_data_q <= sel_byte;
            end
        end
    end

    assign bus.s0_ready  = rdy0;
    assign bus.s1_ready  = rdy1;
    assign bus.enc_data  = enc_data_q;
    assign bus.enc_en    = enc_en_q;
    assign bus.link_up   = link_q;
    assign bus.grant     = grant_q;
    assign bus.underrun  = underrun_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_serdes_tx_scheduler.sv
// ----------------------------------------------------------------------------
// tb_serdes_tx_scheduler
//   Bench for serdes_tx_scheduler. dut_a runs with SYM_CYCLES=10,
//   ALIGN_SYMS=4 against a slot-level reference model; dut_b runs with
//   SYM_CYCLES=2, ALIGN_SYMS=1 for the minimum-parameter scenario.
// ----------------------------------------------------------------------------
module tb_serdes_tx_scheduler;
    localparam int         SYM_A   = 10;
    localparam int         ALIGN_A = 4;
    localparam logic [7:0] IDLE    = 8'hBC;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    always #5 clk = ~clk;

    serdes_tx_scheduler_if ifa ();
    serdes_tx_scheduler_if ifb ();

    serdes_tx_scheduler #(.SYM_CYCLES(SYM_A), .ALIGN_SYMS(ALIGN_A), .IDLE_BYTE(IDLE)) dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .bus   (ifa)
    );

    serdes_tx_scheduler #(.SYM_CYCLES(2), .ALIGN_SYMS(1), .IDLE_BYTE(IDLE)) dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .bus   (ifb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Requester drivers: queue entries are {last, data}.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    bit held0, held1, drop0, drop1;
    int prob0 = 100;
    int prob1 = 100;
    bit obs_r0, obs_r1;
    logic [7:0] exp_q[$];

    // Reference model, one step per clock.
    int         m_c;
    bit         m_link;
    int         m_idles;
    int         m_owner;   // -1 none, else requester index
    int         m_pref;    // requester favoured on a tie
    logic [7:0] m_enc_data;
    bit         m_enc_en, m_under, m_r0, m_r1, m_slot_end;

    function automatic void model_reset();
        m_c = 0; m_link = 0; m_idles = 0; m_owner = -1; m_pref = 0;
        m_enc_data = IDLE; m_enc_en = 0; m_under = 0; m_r0 = 0; m_r1 = 0; m_slot_end = 0;
    endfunction

    function automatic logic [1:0] m_grant();
        if (m_owner < 0) return 2'b00;
        return (m_owner == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic void model_step(bit v0, logic [7:0] d0, bit l0, bit v1, logic [7:0] d1, bit l1);
        bit         v[2];
        logic [7:0] d[2];
        bit         l[2];
        int         w;
        logic [7:0] sel_b;
        v[0] = v0; v[1] = v1; d[0] = d0; d[1] = d1; l[0] = l0; l[1] = l1;
        m_slot_end = ((m_c % SYM_A) == SYM_A - 1);
        m_r0 = 0; m_r1 = 0; m_under = 0;
        m_enc_en = m_slot_end;
        if (m_slot_end) begin
            sel_b = IDLE;
            if (!m_link) begin
                m_idles++;
                if (m_idles == ALIGN_A) m_link = 1;
            end else if (m_owner < 0) begin
                w = -1;
                if (v[0] && v[1]) w = m_pref;
                else if (v[0]) w = 0;
                else if (v[1]) w = 1;
                if (w >= 0) begin
                    sel_b = d[w];
                    if (w == 0) m_r0 = 1; else m_r1 = 1;
                    if (l[w]) m_pref = 1 - m_pref;
                    else m_owner = w;
                end
            end else if (v[m_owner]) begin
                sel_b = d[m_owner];
                if (m_owner == 0) m_r0 = 1; else m_r1 = 1;
                if (l[m_owner]) begin
                    m_pref  = 1 - m_owner;
                    m_owner = -1;
                end
            end else begin
                m_under = 1;
            end
            m_enc_data = sel_b;
        end
        m_c++;
    endfunction

    // One clock of dut_a: drive requesters at negedge, sample ready, step
    // the model, then return 1 time unit after the rising edge.
    task automatic cycle();
        @(negedge clk);
        rst_a = 1'b1;
        if (!held0 && q0.size() > 0 && int'($urandom_range(0, 99)) < prob0) held0 = 1'b1;
        if (!held1 && q1.size() > 0 && int'($urandom_range(0, 99)) < prob1) held1 = 1'b1;
        ifa.s0_valid = held0 && !drop0;
        ifa.s1_valid = held1 && !drop1;
        if (held0) begin
            ifa.s0_data = q0[0][7:0]; ifa.s0_last = q0[0][8];
        end else begin
            ifa.s0_data = 8'($urandom); ifa.s0_last = 1'($urandom);
        end
        if (held1) begin
            ifa.s1_data = q1[0][7:0]; ifa.s1_last = q1[0][8];
        end else begin
            ifa.s1_data = 8'($urandom); ifa.s1_last = 1'($urandom);
        end
        #1;
        obs_r0 = ifa.s0_ready;
        obs_r1 = ifa.s1_ready;
        model_step(ifa.s0_valid, ifa.s0_data, ifa.s0_last, ifa.s1_valid, ifa.s1_data, ifa.s1_last);
        @(posedge clk);
        #1;
        if (obs_r0 && ifa.s0_valid && held0) begin void'(q0.pop_front()); held0 = 1'b0; end
        if (obs_r1 && ifa.s1_valid && held1) begin void'(q1.pop_front()); held1 = 1'b0; end
    endtask

    task automatic do_reset_a();
        @(negedge clk);
        rst_a = 1'b0;
        ifa.s0_valid = 1'b0; ifa.s1_valid = 1'b0;
        q0.delete(); q1.delete();
        held0 = 0; held1 = 0; drop0 = 0; drop1 = 0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset_a();
        n_checks++; if (ifa.enc_data !== IDLE) begin n_fail++; $display("FAIL reset_enc_data: got %h expected %h", ifa.enc_data, IDLE); end
        n_checks++; if (ifa.enc_en !== 1'b0) begin n_fail++; $display("FAIL reset_enc_en: got %b expected 0", ifa.enc_en); end
        n_checks++; if (ifa.link_up !== 1'b0) begin n_fail++; $display("FAIL reset_link_up: got %b expected 0", ifa.link_up); end
        n_checks++; if (ifa.grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b expected 00", ifa.grant); end
        n_checks++; if (ifa.underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b expected 0", ifa.underrun); end
    endtask

    task automatic test_align();
        for (int i = 1; i <= 50; i++) begin
            cycle();
            n_checks++;
            if (ifa.enc_en !== 1'(i % 10 == 0)) begin
                n_fail++; $display("FAIL align_enc_en clk %0d: got %b expected %b", i, ifa.enc_en, (i % 10 == 0));
            end
            if (i % 10 == 0) begin
                n_checks++;
                if (ifa.enc_data !== IDLE) begin n_fail++; $display("FAIL align_enc_data clk %0d: got %h expected %h", i, ifa.enc_data, IDLE); end
            end
            n_checks++;
            if (ifa.link_up !== 1'(i >= 40)) begin
                n_fail++; $display("FAIL align_link_up clk %0d: got %b expected %b", i, ifa.link_up, (i >= 40));
            end
            n_checks++;
            if ((obs_r0 | obs_r1) !== 1'b0) begin n_fail++; $display("FAIL align_ready clk %0d: got %b%b expected 00", i - 1, obs_r1, obs_r0); end
        end
    endtask

    task automatic test_burst();
        logic [7:0] exp_b[3];
        int acc, cyc, last_cyc;
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        q0.push_back({1'b0, 8'h11}); q0.push_back({1'b0, 8'h22}); q0.push_back({1'b1, 8'h33});
        prob0 = 100; acc = 0; cyc = 0; last_cyc = 0;
        while (acc < 3 && cyc < 60) begin
            cycle(); cyc++;
            n_checks++; if (obs_r0 !== m_r0) begin n_fail++; $display("FAIL burst_s0_ready: got %b expected %b", obs_r0, m_r0); end
            n_checks++; if (obs_r1 !== 1'b0) begin n_fail++; $display("FAIL burst_s1_ready: got %b expected 0", obs_r1); end
            if (obs_r0) begin
                if (acc > 0) begin
                    n_checks++;
                    if (cyc - last_cyc != SYM_A) begin n_fail++; $display("FAIL burst_spacing: got %0d expected %0d", cyc - last_cyc, SYM_A); end
                end
                n_checks++; if (ifa.enc_data !== exp_b[acc]) begin n_fail++; $display("FAIL burst_enc_data: got %h expected %h", ifa.enc_data, exp_b[acc]); end
                n_checks++; if (ifa.grant !== ((acc == 2) ? 2'b00 : 2'b01)) begin n_fail++; $display("FAIL burst_grant: got %b expected %b", ifa.grant, (acc == 2) ? 2'b00 : 2'b01); end
                last_cyc = cyc; acc++;
            end
        end
        n_checks++; if (acc != 3) begin n_fail++; $display("FAIL burst_timeout: got %0d bytes expected 3", acc); end
        cyc = 0;
        do begin cycle(); cyc++; end while (!ifa.enc_en && cyc < 15);
        n_checks++; if (ifa.enc_en !== 1'b1) begin n_fail++; $display("FAIL burst_idle_timeout: got no enc_en expected pulse"); end
        n_checks++; if (ifa.enc_data !== IDLE) begin n_fail++; $display("FAIL burst_after_idle: got %h expected %h", ifa.enc_data, IDLE); end
        n_checks++; if (ifa.grant !== 2'b00) begin n_fail++; $display("FAIL burst_after_grant: got %b expected 00", ifa.grant); end
    endtask

    task automatic test_round_robin();
        int acc, cyc;
        logic who;
        do_reset_a();
        for (int i = 0; i < 8; i++) begin
            q0.push_back({1'b1, 8'hA0 + 8'(i)});
            q1.push_back({1'b1, 8'hB0 + 8'(i)});
        end
        acc = 0; cyc = 0;
        while (acc < 16 && cyc < 400) begin
            cycle(); cyc++;
            n_checks++; if (obs_r0 !== m_r0 || obs_r1 !== m_r1) begin n_fail++; $display("FAIL rr_ready: got %b%b expected %b%b", obs_r1, obs_r0, m_r1, m_r0); end
            if (obs_r0 || obs_r1) begin
                who = obs_r1;
                n_checks++; if (who !== 1'(acc % 2)) begin n_fail++; $display("FAIL rr_order #%0d: got s%0d expected s%0d", acc, who, acc % 2); end
                n_checks++;
                if (ifa.enc_data !== ((acc % 2 == 1) ? 8'hB0 : 8'hA0) + 8'(acc / 2)) begin
                    n_fail++; $display("FAIL rr_enc_data #%0d: got %h expected %h", acc, ifa.enc_data, ((acc % 2 == 1) ? 8'hB0 : 8'hA0) + 8'(acc / 2));
                end
                n_checks++; if (ifa.grant !== 2'b00) begin n_fail++; $display("FAIL rr_grant: got %b expected 00", ifa.grant); end
                acc++;
            end
        end
        n_checks++; if (acc != 16) begin n_fail++; $display("FAIL rr_timeout: got %0d bytes expected 16", acc); end
    endtask

    task automatic test_underrun();
        int cyc;
        q1.push_back({1'b0, 8'hC1}); q1.push_back({1'b0, 8'hC2}); q1.push_back({1'b1, 8'hC3});
        cyc = 0;
        while (m_owner != 1 && cyc < 30) begin cycle(); cyc++; end
        n_checks++; if (ifa.grant !== 2'b10) begin n_fail++; $display("FAIL underrun_open_grant: got %b expected 10", ifa.grant); end
        q0.push_back({1'b0, 8'hD1}); q0.push_back({1'b1, 8'hD2});
        drop1 = 1'b1;
        cyc = 0;
        do begin cycle(); cyc++; end while (!m_slot_end && cyc < 15);
        n_checks++; if (obs_r0 !== 1'b0) begin n_fail++; $display("FAIL underrun_s0_ready: got %b expected 0", obs_r0); end
        n_checks++; if (obs_r1 !== 1'b0) begin n_fail++; $display("FAIL underrun_s1_ready: got %b expected 0", obs_r1); end
        n_checks++; if (ifa.underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_pulse: got %b expected 1", ifa.underrun); end
        n_checks++; if (ifa.enc_en !== 1'b1 || ifa.enc_data !== IDLE) begin n_fail++; $display("FAIL underrun_idle: got en=%b data=%h expected en=1 data=%h", ifa.enc_en, ifa.enc_data, IDLE); end
        n_checks++; if (ifa.grant !== 2'b10) begin n_fail++; $display("FAIL underrun_grant: got %b expected 10", ifa.grant); end
        drop1 = 1'b0;
        cycle();
        n_checks++; if (ifa.underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_width: got %b expected 0", ifa.underrun); end
        cyc = 0;
        do begin cycle(); cyc++; end while (!m_slot_end && cyc < 15);
        n_checks++; if (obs_r1 !== 1'b1 || obs_r0 !== 1'b0) begin n_fail++; $display("FAIL underrun_resume_ready: got %b%b expected 10", obs_r1, obs_r0); end
        n_checks++; if (ifa.enc_data !== 8'hC2) begin n_fail++; $display("FAIL underrun_resume_data: got %h expected c2", ifa.enc_data); end
        n_checks++; if (ifa.grant !== 2'b10) begin n_fail++; $display("FAIL underrun_resume_grant: got %b expected 10", ifa.grant); end
        cyc = 0;
        while ((q0.size() > 0 || q1.size() > 0) && cyc < 100) begin
            cycle(); cyc++;
            n_checks++; if (obs_r0 !== m_r0 || obs_r1 !== m_r1) begin n_fail++; $display("FAIL drain_ready: got %b%b expected %b%b", obs_r1, obs_r0, m_r1, m_r0); end
            n_checks++; if (ifa.enc_data !== m_enc_data || ifa.grant !== m_grant()) begin n_fail++; $display("FAIL drain_out: got %h/%b expected %h/%b", ifa.enc_data, ifa.grant, m_enc_data, m_grant()); end
        end
        n_checks++; if (q0.size() != 0 || q1.size() != 0) begin n_fail++; $display("FAIL drain_timeout: got %0d/%0d left expected 0/0", q0.size(), q1.size()); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        q0.push_back({1'b0, 8'h41}); q0.push_back({1'b0, 8'h42});
        q0.push_back({1'b0, 8'h43}); q0.push_back({1'b1, 8'h44});
        cyc = 0;
        while (m_owner != 0 && cyc < 30) begin cycle(); cyc++; end
        for (int i = 0; i < 3; i++) cycle();
        n_checks++; if (ifa.grant !== 2'b01) begin n_fail++; $display("FAIL rmid_pre_grant: got %b expected 01", ifa.grant); end
        do_reset_a();
        n_checks++; if (ifa.link_up !== 1'b0) begin n_fail++; $display("FAIL rmid_link_up: got %b expected 0", ifa.link_up); end
        n_checks++; if (ifa.grant !== 2'b00) begin n_fail++; $display("FAIL rmid_grant: got %b expected 00", ifa.grant); end
        n_checks++; if (ifa.enc_en !== 1'b0) begin n_fail++; $display("FAIL rmid_enc_en: got %b expected 0", ifa.enc_en); end
        for (int i = 1; i <= 12; i++) begin
            cycle();
            n_checks++; if (ifa.enc_en !== 1'(i == 10)) begin n_fail++; $display("FAIL rmid_first_pulse clk %0d: got %b expected %b", i, ifa.enc_en, (i == 10)); end
            n_checks++; if (ifa.link_up !== 1'b0) begin n_fail++; $display("FAIL rmid_realign clk %0d: got %b expected 0", i, ifa.link_up); end
        end
    endtask

    task automatic test_random();
        logic [7:0] e;
        int len;
        do_reset_a();
        exp_q.delete();
        prob0 = 70; prob1 = 70;
        for (int i = 0; i < 800; i++) begin
            if (q0.size() == 0 && $urandom_range(0, 3) == 0) begin
                len = int'($urandom_range(1, 4));
                for (int k = 0; k < len; k++) q0.push_back({1'(k == len - 1), 8'($urandom)});
            end
            if (q1.size() == 0 && $urandom_range(0, 3) == 0) begin
                len = int'($urandom_range(1, 4));
                for (int k = 0; k < len; k++) q1.push_back({1'(k == len - 1), 8'($urandom)});
            end
            drop0 = ($urandom_range(0, 15) == 0);
            drop1 = ($urandom_range(0, 15) == 0);
            cycle();
            if (m_enc_en) exp_q.push_back(m_enc_data);
            n_checks++; if (obs_r0 !== m_r0 || obs_r1 !== m_r1) begin n_fail++; $display("FAIL rand_ready cyc %0d: got %b%b expected %b%b", i, obs_r1, obs_r0, m_r1, m_r0); end
            n_checks++; if (ifa.grant !== m_grant()) begin n_fail++; $display("FAIL rand_grant cyc %0d: got %b expected %b", i, ifa.grant, m_grant()); end
            n_checks++; if (ifa.link_up !== m_link) begin n_fail++; $display("FAIL rand_link_up cyc %0d: got %b expected %b", i, ifa.link_up, m_link); end
            n_checks++; if (ifa.underrun !== m_under) begin n_fail++; $display("FAIL rand_underrun cyc %0d: got %b expected %b", i, ifa.underrun, m_under); end
            n_checks++; if (ifa.enc_en !== m_enc_en) begin n_fail++; $display("FAIL rand_enc_en cyc %0d: got %b expected %b", i, ifa.enc_en, m_enc_en); end
            if (ifa.enc_en === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_enc_data cyc %0d: got %h expected no pulse", i, ifa.enc_data);
                end else begin
                    e = exp_q.pop_front();
                    if (ifa.enc_data !== e) begin n_fail++; $display("FAIL rand_enc_data cyc %0d: got %h expected %h", i, ifa.enc_data, e); end
                end
            end
        end
        drop0 = 0; drop1 = 0; prob0 = 100; prob1 = 100;
    endtask

    task automatic test_small_params();
        bit acc;
        acc = 0;
        @(negedge clk);
        rst_b = 1'b0; ifb.s0_valid = 1'b0; ifb.s1_valid = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            rst_b = 1'b1;
            ifb.s0_valid = !acc; ifb.s0_data = 8'h5A; ifb.s0_last = 1'b1;
            #1;
            n_checks++; if (ifb.s0_ready !== 1'(k == 4)) begin n_fail++; $display("FAIL small_ready clk %0d: got %b expected %b", k - 1, ifb.s0_ready, (k == 4)); end
            if (ifb.s0_ready === 1'b1) acc = 1;
            @(posedge clk);
            #1;
            n_checks++; if (ifb.enc_en !== 1'(k % 2 == 0)) begin n_fail++; $display("FAIL small_enc_en clk %0d: got %b expected %b", k, ifb.enc_en, (k % 2 == 0)); end
            n_checks++; if (ifb.link_up !== 1'(k >= 2)) begin n_fail++; $display("FAIL small_link_up clk %0d: got %b expected %b", k, ifb.link_up, (k >= 2)); end
            if (k == 2) begin
                n_checks++; if (ifb.enc_data !== IDLE) begin n_fail++; $display("FAIL small_align_data: got %h expected %h", ifb.enc_data, IDLE); end
            end
            if (k == 4) begin
                n_checks++; if (ifb.enc_data !== 8'h5A) begin n_fail++; $display("FAIL small_data: got %h expected 5a", ifb.enc_data); end
            end
        end
    endtask

    initial begin
        ifa.s0_valid = 0; ifa.s0_data = 0; ifa.s0_last = 0;
        ifa.s1_valid = 0; ifa.s1_data = 0; ifa.s1_last = 0;
        ifb.s0_valid = 0; ifb.s0_data = 0; ifb.s0_last = 0;
        ifb.s1_valid = 0; ifb.s1_data = 0; ifb.s1_last = 0;
        model_reset();
        test_reset();
        test_align();
        test_burst();
        test_round_robin();
        test_underrun();
        test_reset_mid();
        test_random();
        test_small_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
